// File: rtl/lfsr_counter_bank_if.sv
// Request/response/clear bundle for lfsr_counter_bank: the master issues
// probes and increments/decrements, the slave (the bank) answers one cycle later.
interface lfsr_counter_bank_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             op_valid;
  logic             op_ready;
  logic             op_we;
  logic             op_inc;
  logic [AW-1:0]    op_addr;
  logic             clr_start;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_zero;
  logic             rsp_sat;
  logic [WIDTH-1:0] rsp_value;
  logic [AW-1:0]    rsp_addr;

  modport master (
    output op_valid, op_we, op_inc, op_addr, clr_start,
    input  op_ready, busy, rsp_valid, rsp_zero, rsp_sat, rsp_value, rsp_addr
  );

  modport slave (
    input  op_valid, op_we, op_inc, op_addr, clr_start,
    output op_ready, busy, rsp_valid, rsp_zero, rsp_sat, rsp_value, rsp_addr
  );
endinterface

// File: rtl/lfsr_counter_bank.sv
// Bank of DEPTH saturating XNOR-LFSR counters with a one-per-cycle clear sweep.
// Optional occupancy counter (occ_count) is built only when LFSR_BANK_OCC_EN is defined.
package lfsr_counter_bank_pkg;

  // Forward step: shift left, feed back the XNOR of the tapped bits.
  function automatic logic [15:0] lfsr_succ(input int width, input logic [15:0] taps,
                                            input logic [15:0] s);
    logic [15:0] mask;
    logic        fb;
    mask = 16'((17'd1 << width) - 17'd1);
    fb   = ~^(s & taps);
    return ((s << 1) | 16'(fb)) & mask;
  endfunction

  // Backward step: the top tap is always set, so the dropped MSB is recoverable
  // from the feedback bit and the parity of the remaining tapped bits.
  function automatic logic [15:0] lfsr_pred(input int width, input logic [15:0] taps,
                                            input logic [15:0] s);
    logic [15:0] low;
    logic        msb;
    low = s >> 1;
    msb = ~s[0] ^ (^(low & taps));
    return low | (16'(msb) << (width - 1));
  endfunction

endpackage

module lfsr_counter_bank
  import lfsr_counter_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
  // Sequence index 2^WIDTH-2 is the predecessor of the all-zeros state.
  parameter logic [WIDTH-1:0] SAT_STATE = WIDTH'(lfsr_pred(WIDTH, 16'(TAPS), 16'd0)),
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               rstb,
  lfsr_counter_bank_if.slave bus
`ifdef LFSR_BANK_OCC_EN
  ,
  output logic [AW:0]        occ_count
`endif
);

  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;

  logic             p_valid_q, p_we_q, p_inc_q;
  logic [AW-1:0]    p_addr_q;

  logic [WIDTH-1:0] cnt_q [DEPTH];

  logic             rsp_valid_q, rsp_zero_q, rsp_sat_q;
  logic [WIDTH-1:0] rsp_value_q;
  logic [AW-1:0]    rsp_addr_q;

  logic             accept;
  logic             op_wr;
  logic             sweep_wr;
  logic             sweep_last;
  logic [WIDTH-1:0] cur_val, new_val;

  assign bus.op_ready = (state_q == STATE_IDLE) && !bus.clr_start;
  assign bus.busy     = (state_q == STATE_CLEAR);
  assign accept       = bus.op_valid && bus.op_ready;
  assign sweep_wr     = (state_q == STATE_CLEAR);
  assign sweep_last   = sweep_wr && (clr_idx_q == AW'(DEPTH - 1));

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      STATE_IDLE: begin
        if (bus.clr_start) begin
          state_d   = STATE_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (sweep_last) state_d = STATE_IDLE;
      end
    endcase
  end

  // The previous request to the same address was written on the edge that
  // loaded this one, so reading the array here already sees its result.
  always_comb begin
    cur_val = cnt_q[p_addr_q];
    new_val = cur_val;
    if (p_we_q) begin
      if (p_inc_q) begin
        if (cur_val != SAT_STATE) new_val = WIDTH'(lfsr_succ(WIDTH, 16'(TAPS), 16'(cur_val)));
      end else begin
        if (cur_val != '0) new_val = WIDTH'(lfsr_pred(WIDTH, 16'(TAPS), 16'(cur_val)));
      end
    end
  end

  assign op_wr = p_valid_q && p_we_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      state_q     <= STATE_IDLE;
      clr_idx_q   <= '0;
      p_valid_q   <= 1'b0;
      p_we_q      <= 1'b0;
      p_inc_q     <= 1'b0;
      p_addr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_sat_q   <= 1'b0;
      rsp_value_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      p_valid_q   <= accept;
      p_we_q      <= bus.op_we;
      p_inc_q     <= bus.op_inc;
      p_addr_q    <= bus.op_addr;
      rsp_valid_q <= p_valid_q;
      if (p_valid_q) begin
        rsp_zero_q  <= (new_val == '0);
        rsp_sat_q   <= (new_val == SAT_STATE);
        rsp_value_q <= new_val;
        rsp_addr_q  <= p_addr_q;
      end
    end
  end

  // NOTE: the counters are a flop array rather than a RAM because reset must
  // clear every entry asynchronously in one step.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (sweep_wr) begin
      cnt_q[clr_idx_q] <= '0;
    end else if (op_wr) begin
      cnt_q[p_addr_q] <= new_val;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_sat   = rsp_sat_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_addr  = rsp_addr_q;

`ifdef LFSR_BANK_OCC_EN
  logic [AW:0] occ_q;

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      occ_q <= '0;
    end else if (sweep_last) begin
      occ_q <= '0;
    end else if (sweep_wr) begin
      if (cnt_q[clr_idx_q] != '0) occ_q <= occ_q - 1'b1;
    end else if (op_wr) begin
      if (cur_val == '0 && new_val != '0)      occ_q <= occ_q + 1'b1;
      else if (cur_val != '0 && new_val == '0) occ_q <= occ_q - 1'b1;
    end
  end

  assign occ_count = occ_q;
`else
  // Occupancy tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_lfsr_counter_bank.sv
// Directed bench for lfsr_counter_bank: LFSR stepping, saturation, underflow,
// back-to-back forwarding, clear sweep and asynchronous reset.
module tb_lfsr_counter_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  lfsr_counter_bank_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

`ifdef LFSR_BANK_OCC_EN
  logic [AW:0] occ_count;
`endif

  lfsr_counter_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .rstb (rstb),
    .bus  (bus)
`ifdef LFSR_BANK_OCC_EN
    ,
    .occ_count (occ_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic inc, input logic [AW-1:0] addr);
    bus.op_valid = 1'b1;
    bus.op_we    = we;
    bus.op_inc   = inc;
    bus.op_addr  = addr;
  endtask

  // One isolated request; returns at the negedge where its response is visible.
  task automatic run_op(input logic we, input logic inc, input logic [AW-1:0] addr);
    @(negedge clk);
    drive(we, inc, addr);
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] val, input logic zero, input logic sat);
    check({tag, "_valid"}, bus.rsp_valid, 1'b1);
    check({tag, "_value"}, bus.rsp_value, val);
    check({tag, "_zero"},  bus.rsp_zero,  zero);
    check({tag, "_sat"},   bus.rsp_sat,   sat);
    check({tag, "_addr"},  bus.rsp_addr,  addr);
  endtask

  task automatic checked_op(input string tag, input logic we, input logic inc,
                            input logic [AW-1:0] addr, input logic [WIDTH-1:0] val,
                            input logic zero, input logic sat);
    run_op(we, inc, addr);
    check_rsp(tag, addr, val, zero, sat);
    @(negedge clk);
    check({tag, "_one_cycle"}, bus.rsp_valid, 1'b0);
  endtask

  logic [WIDTH-1:0] exp_up [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
  int sweep_cycles;

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_we     = 1'b0;
    bus.op_inc    = 1'b0;
    bus.op_addr   = '0;
    bus.clr_start = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_zero",  bus.rsp_zero,  1'b0);
    check("rst_rsp_sat",   bus.rsp_sat,   1'b0);
    check("rst_rsp_value", bus.rsp_value, 8'h00);
    check("rst_rsp_addr",  bus.rsp_addr,  4'h0);
    check("rst_busy",      bus.busy,      1'b0);
    rstb = 1'b1;
    @(negedge clk);
    check("rel_op_ready", bus.op_ready, 1'b1);

    // Five back-to-back increments of addr 3
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) check_rsp($sformatf("inc3_%0d", i - 2), 4'd3, exp_up[i-2], 1'b0, 1'b0);
      if (i < 5) drive(1'b1, 1'b1, 4'd3);
      else       bus.op_valid = 1'b0;
    end

    // Underflow guard and probe
    checked_op("dec5_zero", 1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0);
    checked_op("probe5",    1'b0, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0);

    // Saturation: 253 steps reach C0, the 254th reaches SAT_STATE 80
    repeat (253) run_op(1'b1, 1'b1, 4'd0);
    checked_op("sat_reach", 1'b1, 1'b1, 4'd0, 8'h80, 1'b0, 1'b1);
    checked_op("sat_hold",  1'b1, 1'b1, 4'd0, 8'h80, 1'b0, 1'b1);
    checked_op("sat_probe", 1'b0, 1'b0, 4'd0, 8'h80, 1'b0, 1'b1);
    checked_op("sat_dec",   1'b1, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0);
    checked_op("sat_reinc", 1'b1, 1'b1, 4'd0, 8'h80, 1'b0, 1'b1);

    // Increment then decrement addr 2 on consecutive cycles
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd2);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd2);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check_rsp("b2b_inc", 4'd2, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check_rsp("b2b_dec", 4'd2, 8'h00, 1'b1, 1'b0);

    // Probes never modify
    checked_op("probe3",       1'b0, 1'b0, 4'd3, 8'h1E, 1'b0, 1'b0);
    checked_op("probe3_again", 1'b0, 1'b0, 4'd3, 8'h1E, 1'b0, 1'b0);

    // Clear sweep with a request in flight when clr_start rises
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd7);
    @(negedge clk);
    bus.op_valid  = 1'b0;
    bus.clr_start = 1'b1;
    #1;
    check("ready_low_clr", bus.op_ready, 1'b0);
    @(negedge clk);
    bus.clr_start = 1'b0;
    check_rsp("inflight7", 4'd7, 8'h01, 1'b0, 1'b0);
    check("busy_start", bus.busy, 1'b1);
    sweep_cycles = 0;
    while (bus.busy && sweep_cycles < 40) begin
      sweep_cycles++;
      if (sweep_cycles == 3) check("ready_low_busy", bus.op_ready, 1'b0);
      bus.clr_start = (sweep_cycles == 5);
      @(negedge clk);
    end
    bus.clr_start = 1'b0;
    check("sweep_len", sweep_cycles, 16);
    check("ready_after_sweep", bus.op_ready, 1'b1);
    checked_op("clr_probe0", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    checked_op("clr_probe3", 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
    checked_op("clr_probe7", 1'b0, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a sweep
    run_op(1'b1, 1'b1, 4'd4);
    run_op(1'b1, 1'b1, 4'd12);
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_pre_rst", bus.busy, 1'b1);
    #2 rstb = 1'b0;
    #1;
    check("midsweep_busy", bus.busy, 1'b0);
    check("midsweep_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("midsweep_ready", bus.op_ready, 1'b1);
    checked_op("rst_probe4",  1'b0, 1'b0, 4'd4,  8'h00, 1'b1, 1'b0);
    checked_op("rst_probe12", 1'b0, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0);

    // Reset with a response showing and another request in flight
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd9);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd10);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check_rsp("pre_rst9", 4'd9, 8'h01, 1'b0, 1'b0);
    #2 rstb = 1'b0;
    #1;
    check("rst_drop_valid", bus.rsp_valid, 1'b0);
    check("rst_drop_value", bus.rsp_value, 8'h00);
    check("rst_drop_addr",  bus.rsp_addr,  4'h0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("no_rsp_after_rst_%0d", i), bus.rsp_valid, 1'b0);
    end
    checked_op("rst_probe9",  1'b0, 1'b0, 4'd9,  8'h00, 1'b1, 1'b0);
    checked_op("rst_probe10", 1'b0, 1'b0, 4'd10, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lfsr_counter_bank.md
LFSR_COUNTER_BANK -- requirements
Module: lfsr_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (4..16).
REQ-002 SHALL have parameter DEPTH, default 16, number of counters (power of 2, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter TAPS, default 8'hB8, feedback tap mask; bit WIDTH-1 always set.
REQ-004 SHALL have parameter SAT_STATE, default = sequence index 2^WIDTH-2 (last state before wrap), computed by a constant function.
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 rstb  in  1  asynchronous, active-low reset.
REQ-007 op_valid  in  1  operation request.
REQ-008 op_ready  out  1  request accepted when op_valid & op_ready.
REQ-009 op_we  in  1  1 = change, 0 = probe.
REQ-010 op_inc  in  1  1 = increment, 0 = decrement (when op_we=1).
REQ-011 op_addr  in  AW  counter index.
REQ-012 clr_start  in  1  pulse; start clear-all sweep.
REQ-013 busy  out  1  sweep in progress.
REQ-014 rsp_valid / rsp_zero / rsp_sat  out  1 each  response strobe; post-op value zero; post-op value at SAT_STATE.
REQ-015 rsp_value  out  WIDTH  post-op counter state.
REQ-016 rsp_addr  out  AW  address of response.

Function
REQ-017 Zero state SHALL be all-zeros; increment SHALL be next = {s[WIDTH-2:0], fb}, fb = XNOR-reduce of s bits selected by TAPS.
REQ-018 Decrement SHALL be the exact inverse of increment.
REQ-019 Increment at SAT_STATE SHALL leave the counter unchanged (saturate, no wrap).
REQ-020 Decrement at zero SHALL leave the counter unchanged (no underflow).
REQ-021 Probe SHALL never modify the counter.
REQ-022 Request accepted at edge N SHALL update the counter at edge N+1; rsp_* SHALL be valid during the cycle after edge N+1 for exactly one cycle per request.
REQ-023 One request per cycle SHALL be sustainable; back-to-back requests to the same address SHALL see the forwarded result of the previous one.
REQ-024 FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR zeroes one counter per cycle from index 0 to DEPTH-1, then returns to IDLE.
REQ-025 op_ready SHALL be 1 in IDLE and 0 in CLEAR or in the cycle clr_start is high; busy SHALL be 1 exactly while in CLEAR.
REQ-026 An in-flight request at clr_start SHALL complete and respond before the sweep writes its address.
REQ-027 clr_start during CLEAR SHALL be ignored.
REQ-028 A sweep SHALL take DEPTH cycles; busy falls the cycle after index DEPTH-1 is cleared.

Reset
REQ-029 rstb low SHALL asynchronously zero all counters, return the FSM to IDLE, and drive rsp_valid=0, rsp_zero=0, rsp_sat=0, rsp_value=0, rsp_addr=0, busy=0; op_ready=1 after release.
REQ-030 Reset during a sweep or with a request in flight SHALL abandon it with no response.

Configuration
REQ-031 With LFSR_BANK_OCC_EN defined, output occ_count [AW:0] SHALL track the number of nonzero counters, updating with each write, zeroed by reset and by sweep completion.
REQ-032 Without LFSR_BANK_OCC_EN, occ_count SHALL be absent and no occupancy logic built.

Verification
REQ-033 Four increments of addr 3 from reset -> rsp_value 01,03,07,0F; fifth -> 1E, rsp_zero=0.
REQ-034 Decrement of addr 5 at zero -> rsp_value 00, rsp_zero=1, counter unchanged.
REQ-035 2^WIDTH-2 increments of addr 0, then one more -> rsp_value=SAT_STATE, rsp_sat=1 both times.
REQ-036 Increment addr 2 then decrement addr 2 on consecutive cycles -> responses 01 then 00, no bubble.
REQ-037 Load several counters, pulse clr_start -> busy high 16 cycles, op_ready low, all probes afterwards return zero.
REQ-038 rstb low mid-sweep -> busy=0, rsp_valid=0 immediately, all counters zero.
